// File: rtl/serial_and_if.sv
// Operand/result handshake bundle for the bit-serial AND controller.
interface serial_and_if #(
    parameter int unsigned WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid,
        input  in_ready,
        output a,
        output b,
        input  out_valid,
        output out_ready,
        input  out,
        input  busy
    );

    modport slave (
        input  in_valid,
        output in_ready,
        input  a,
        input  b,
        output out_valid,
        input  out_ready,
        output out,
        output busy
    );
endinterface

// File: rtl/serial_and_ctrl.sv
// Bit-serial WIDTH-bit AND: one my_and gate time-shared over all bit
// positions, LSB first, between a valid/ready operand and result channel.
module my_and (
    input  logic a,
    input  logic b,
    output logic y
);
    assign y = a & b;
endmodule

module serial_and_ctrl #(
    parameter int unsigned WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_and_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic               busy_q, busy_d;

    logic               and_a;
    logic               and_b;
    logic               and_y;

    // The single shared gate sees the operand bits selected by the counter.
    assign and_a = a_q[cnt_q];
    assign and_b = b_q[cnt_q];

    my_and u_and (
        .a (and_a),
        .b (and_b),
        .y (and_y)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_q) begin
                    a_d      = bus.a;
                    b_d      = bus.b;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[cnt_q] = and_y;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Handshake flags are registered copies of the next state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
        busy_d      = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = result_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_serial_and_ctrl.sv
// Scoreboard bench for serial_and_ctrl: directed scenarios plus random ops.
module tb_serial_and_ctrl;
    localparam int unsigned WIDTH = 16;
    localparam int          TMO   = 400;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_and_if #(.WIDTH(WIDTH)) bus_if ();

    serial_and_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    typedef struct {
        logic [WIDTH-1:0] exp;
        int               acc;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    bit   rnd_rdy = 1'b0;
    bit   prev_ov = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Random consumer backpressure during the random phase.
    always @(posedge clk) begin
        if (rnd_rdy) begin
            #1;
            if (rnd_rdy) bus_if.out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Model: every accepted pair yields a & b after WIDTH cycles; reset discards.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            prev_ov = 1'b0;
        end else begin
            if (bus_if.out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    fail_now("spurious_out_valid");
                end else begin
                    if (!prev_ov) chk("latency", 64'(cyc), 64'(sb[0].acc + int'(WIDTH)));
                    chk("result", 64'(bus_if.out), 64'(sb[0].exp));
                    if (bus_if.out_ready) void'(sb.pop_front());
                end
            end
            if (bus_if.in_valid && bus_if.in_ready === 1'b1) begin
                exp_t e;
                e.exp = bus_if.a & bus_if.b;
                e.acc = cyc + 1;
                sb.push_back(e);
            end
            prev_ov = (bus_if.out_valid === 1'b1);
        end
    end

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                        input bit hold, output int acc);
        int n;
        bus_if.in_valid = 1'b1;
        bus_if.a        = av;
        bus_if.b        = bv;
        n               = 0;
        acc             = -1;
        @(negedge clk);
        while (bus_if.in_ready !== 1'b1) begin
            n++;
            if (n > TMO) begin
                fail_now("accept_timeout");
                bus_if.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        if (!hold) bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || bus_if.busy !== 1'b0) && n < TMO) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (n >= TMO) fail_now("drain_timeout");
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_in_ready"}, 64'(bus_if.in_ready), 64'(1));
        chk({name, "_out_valid"}, 64'(bus_if.out_valid), 64'(0));
        chk({name, "_busy"}, 64'(bus_if.busy), 64'(0));
    endtask

    initial begin
        int               acc;
        int               n;
        int               accs[4];
        logic [WIDTH-1:0] va[4];
        logic [WIDTH-1:0] vb[4];

        bus_if.in_valid  = 1'b0;
        bus_if.a         = '0;
        bus_if.b         = '0;
        bus_if.out_ready = 1'b1;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic op with in_ready/busy/out_valid tracked cycle by cycle.
        send(16'hFFFF, 16'h0F0F, 1'b0, acc);
        for (int i = 0; i < int'(WIDTH); i++) begin
            chk("run_in_ready", 64'(bus_if.in_ready), 64'(0));
            chk("run_out_valid", 64'(bus_if.out_valid), 64'(0));
            chk("run_busy", 64'(bus_if.busy), 64'(1));
            @(posedge clk);
            #1;
        end
        chk("done_out_valid", 64'(bus_if.out_valid), 64'(1));
        chk("done_in_ready", 64'(bus_if.in_ready), 64'(0));
        chk("done_busy", 64'(bus_if.busy), 64'(1));
        @(posedge clk);
        #1;
        chk_idle("after_emit");

        // Backpressure in DONE.
        send(16'hA5A5, 16'h3C3C, 1'b0, acc);
        bus_if.out_ready = 1'b0;
        n = 0;
        while (bus_if.out_valid !== 1'b1 && n < TMO) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= TMO) fail_now("bp_valid_timeout");
        for (int i = 0; i < 10; i++) begin
            chk("bp_hold_valid", 64'(bus_if.out_valid), 64'(1));
            chk("bp_hold_out", 64'(bus_if.out), 64'(16'h2424));
            @(posedge clk);
            #1;
        end
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("bp_release");

        // Operands offered while busy must be ignored.
        send(16'h00FF, 16'hFFFF, 1'b0, acc);
        bus_if.in_valid = 1'b1;
        bus_if.a        = 16'hFFFF;
        bus_if.b        = 16'hFFFF;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("ignore_in_ready", 64'(bus_if.in_ready), 64'(0));
        end
        bus_if.in_valid = 1'b0;
        drain();
        chk("ignore_single_result", 64'(sb.size()), 64'(0));

        // Reset in the middle of RUN discards the operation.
        send(16'h5555, 16'hFFFF, 1'b0, acc);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk_idle("midrun_reset");
        repeat (20) @(posedge clk);
        #1;
        send(16'h1234, 16'hFFFF, 1'b0, acc);
        drain();

        // Back-to-back with in_valid held high.
        va[0] = 16'h000A; vb[0] = 16'h000C;
        va[1] = 16'h0000; vb[1] = 16'hFFFF;
        va[2] = 16'hFFFF; vb[2] = 16'hFFFF;
        va[3] = 16'hFFFF; vb[3] = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            send(va[i], vb[i], (i < 3), accs[i]);
            if (i > 0) chk("b2b_spacing", 64'(accs[i] - accs[i-1]), 64'(WIDTH + 2));
        end
        drain();

        // Random operands with random consumer stalls.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            send(WIDTH'($urandom), WIDTH'($urandom), 1'b0, acc);
        end
        n = 0;
        while (sb.size() != 0 && n < TMO) begin
            @(posedge clk);
            n++;
        end
        rnd_rdy = 1'b0;
        @(posedge clk);
        #1;
        bus_if.out_ready = 1'b1;
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
